// File: rtl/perceptron_pkg.sv
// Shared types and constants for the accumulator dump sequencer.
// Holds the dump FSM state enum, the optional header byte and default sizing.
package perceptron_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SEND,
    WAIT_HI,
    WAIT_LO,
    DONE
  } dump_state_t;

  localparam logic [7:0] HDR_BYTE    = 8'hA5;
  localparam int         NBYTES_DEF  = 16;
  localparam int         BUSY_TO_DEF = 15;

endpackage

// File: rtl/acc_dump_seq_if.sv
// Bundle between the dump sequencer, the ctrl block, the accumulator mux and the uart.
// master = surrounding system, slave = the sequencer.
interface acc_dump_seq_if;
  logic       start;
  logic       busy_tx;
  logic [7:0] mux_data;
  logic [3:0] sel;
  logic [7:0] data_tx;
  logic       transmit;
  logic       hold;
  logic       done;
  logic       err;

  modport master (
    output start, busy_tx, mux_data,
    input  sel, data_tx, transmit, hold, done, err
  );

  modport slave (
    input  start, busy_tx, mux_data,
    output sel, data_tx, transmit, hold, done, err
  );
endinterface

// File: rtl/dump_timer.sv
// Busy-rise watchdog: loaded with BUSY_TO while a byte is sent, counts down while
// waiting for busy_tx to rise, and flags expiry on the last waiting cycle.
module dump_timer
  import perceptron_pkg::*;
#(
  parameter int BUSY_TO = BUSY_TO_DEF
) (
  input  logic clk,
  input  logic nRst,
  input  logic load,
  input  logic run,
  output logic expire
);

  localparam int W = $clog2(BUSY_TO + 1);

  logic [W-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      count <= '0;
    end else if (load) begin
      count <= W'(BUSY_TO);
    end else if (run && count != '0) begin
      count <= count - W'(1);
    end
  end

  assign expire = run && (count == W'(1));

endmodule

// File: rtl/acc_dump_seq.sv
// Streams NBYTES accumulator bytes to a uart, one transmit strobe per byte,
// holding the accumulator while dumping. `DUMP_HEADER_EN prepends header byte 8'hA5.
module acc_dump_seq
  import perceptron_pkg::*;
#(
  parameter int NBYTES    = NBYTES_DEF,
  parameter int MSB_FIRST = 0,
  parameter int BUSY_TO   = BUSY_TO_DEF
) (
  input logic           clk,
  input logic           nRst,
  acc_dump_seq_if.slave bus
);

  localparam logic [3:0] FIRST = (MSB_FIRST != 0) ? 4'(NBYTES - 1) : 4'd0;
  localparam logic [3:0] LAST  = (MSB_FIRST != 0) ? 4'd0 : 4'(NBYTES - 1);

  dump_state_t state;
  logic [3:0]  sel_q;
  logic [7:0]  data_q;
  logic        transmit_q, hold_q, done_q, err_q;
  logic [7:0]  tx_byte;
  logic        timer_load, timer_run, expire, advance;

`ifdef DUMP_HEADER_EN
  logic hdr_pend;
  assign tx_byte = hdr_pend ? HDR_BYTE : bus.mux_data;
`else
  assign tx_byte = bus.mux_data;
`endif

  assign timer_load = (state == SEND);
  assign timer_run  = (state == WAIT_HI);

  dump_timer #(.BUSY_TO(BUSY_TO)) u_timer (
    .clk    (clk),
    .nRst   (nRst),
    .load   (timer_load),
    .run    (timer_run),
    .expire (expire)
  );

  // A timed-out byte is treated as sent, so both exits share the advance step.
  assign advance = ((state == WAIT_LO) && !bus.busy_tx) ||
                   ((state == WAIT_HI) && !bus.busy_tx && expire);

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state      <= IDLE;
      sel_q      <= '0;
      data_q     <= '0;
      transmit_q <= 1'b0;
      hold_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef DUMP_HEADER_EN
      hdr_pend   <= 1'b0;
`endif
    end else begin
      transmit_q <= 1'b0;
      done_q     <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start && !bus.busy_tx) begin
            state  <= SETUP;
            sel_q  <= FIRST;
            err_q  <= 1'b0;
            hold_q <= 1'b1;
`ifdef DUMP_HEADER_EN
            hdr_pend <= 1'b1;
`endif
          end
        end
        SETUP: begin
          // mux_data has had a full cycle to settle on sel_q; capture it with the strobe.
          if (!bus.busy_tx) begin
            state      <= SEND;
            transmit_q <= 1'b1;
            data_q     <= tx_byte;
          end
        end
        SEND:    state <= WAIT_HI;
        WAIT_HI: begin
          if (bus.busy_tx) state <= WAIT_LO;
          else if (expire) err_q <= 1'b1;
        end
        WAIT_LO: ;
        DONE: begin
          state  <= IDLE;
          hold_q <= 1'b0;
        end
        default: state <= IDLE;
      endcase

      if (advance) begin
`ifdef DUMP_HEADER_EN
        if (hdr_pend) begin
          hdr_pend <= 1'b0;
          state    <= SETUP;
        end else
`endif
        if (sel_q == LAST) begin
          state  <= DONE;
          done_q <= 1'b1;
        end else begin
          state <= SETUP;
          sel_q <= (MSB_FIRST != 0) ? sel_q - 4'd1 : sel_q + 4'd1;
        end
      end
    end
  end

  assign bus.sel      = sel_q;
  assign bus.data_tx  = data_q;
  assign bus.transmit = transmit_q;
  assign bus.hold     = hold_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;

endmodule

// File: tb/tb_acc_dump_seq.sv
// Scoreboard bench for acc_dump_seq: an LSB-first and an MSB-first instance share
// clk/nRst; each has a 10-cycle-busy uart model and an accumulator mux.
module tb_acc_dump_seq;
  import perceptron_pkg::*;

  localparam int NB = NBYTES_DEF;
`ifdef DUMP_HEADER_EN
  localparam int NTX = NB + 1;
`else
  localparam int NTX = NB;
`endif
  localparam logic [127:0] SPEC_ACC = 128'h0F0E0D0C0B0A09080706050403020100;

  typedef struct packed {
    logic [3:0] sel;
    logic [7:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic nRst = 1'b0;
  always #5 clk = ~clk;

  acc_dump_seq_if bus0 ();
  acc_dump_seq_if bus1 ();

  acc_dump_seq #(.NBYTES(NB), .MSB_FIRST(0), .BUSY_TO(BUSY_TO_DEF)) dut_lsb (
    .clk(clk), .nRst(nRst), .bus(bus0));
  acc_dump_seq #(.NBYTES(NB), .MSB_FIRST(1), .BUSY_TO(BUSY_TO_DEF)) dut_msb (
    .clk(clk), .nRst(nRst), .bus(bus1));

  logic [127:0] acc0, acc1;
  logic stuck = 1'b0;
  logic force_busy = 1'b0;
  int ucnt0, ucnt1;

  assign bus0.mux_data = acc0[{bus0.sel, 3'b000} +: 8];
  assign bus1.mux_data = acc1[{bus1.sel, 3'b000} +: 8];

  always @(posedge clk or negedge nRst) begin
    if (!nRst) ucnt0 <= 0;
    else if (bus0.transmit && !stuck) ucnt0 <= 10;
    else if (ucnt0 != 0) ucnt0 <= ucnt0 - 1;
  end
  always @(posedge clk or negedge nRst) begin
    if (!nRst) ucnt1 <= 0;
    else if (bus1.transmit && !stuck) ucnt1 <= 10;
    else if (ucnt1 != 0) ucnt1 <= ucnt1 - 1;
  end
  assign bus0.busy_tx = (ucnt0 != 0) || force_busy;
  assign bus1.busy_tx = (ucnt1 != 0) || force_busy;

  int checks = 0;
  int failures = 0;
  exp_t exp0[$];
  exp_t exp1[$];
  int tx0 = 0, tx1 = 0, done0 = 0, done1 = 0;
  int cyc = 0, last0 = 0, gap0 = 0;

  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (bus0.done) done0++;
    if (bus1.done) done1++;
    if (bus0.transmit) begin
      tx0++;
      gap0  = cyc - last0;
      last0 = cyc;
      checks++;
      if (bus0.busy_tx !== 1'b0) begin
        failures++;
        $display("FAIL tx0_while_busy: busy_tx=%b required 0", bus0.busy_tx);
      end
      checks++;
      if (exp0.size() == 0) begin
        failures++;
        $display("FAIL tx0_unexpected: sel=%0d data=%02h with no byte expected", bus0.sel, bus0.data_tx);
      end else begin
        e = exp0.pop_front();
        if ({bus0.sel, bus0.data_tx} !== e) begin
          failures++;
          $display("FAIL tx0_byte: got sel=%0d data=%02h required sel=%0d data=%02h",
                   bus0.sel, bus0.data_tx, e.sel, e.data);
        end
      end
    end
    if (bus1.transmit) begin
      tx1++;
      checks++;
      if (exp1.size() == 0) begin
        failures++;
        $display("FAIL tx1_unexpected: sel=%0d data=%02h with no byte expected", bus1.sel, bus1.data_tx);
      end else begin
        e = exp1.pop_front();
        if ({bus1.sel, bus1.data_tx} !== e) begin
          failures++;
          $display("FAIL tx1_byte: got sel=%0d data=%02h required sel=%0d data=%02h",
                   bus1.sel, bus1.data_tx, e.sel, e.data);
        end
      end
    end
  end

  function automatic void push_dump(input int which, input logic [127:0] acc);
    exp_t e;
    logic [3:0] s;
    s = (which == 1) ? 4'(NB - 1) : 4'd0;
`ifdef DUMP_HEADER_EN
    e.sel  = s;
    e.data = HDR_BYTE;
    if (which == 1) exp1.push_back(e); else exp0.push_back(e);
`endif
    for (int i = 0; i < NB; i++) begin
      s      = (which == 1) ? 4'(NB - 1 - i) : 4'(i);
      e.sel  = s;
      e.data = acc[{s, 3'b000} +: 8];
      if (which == 1) exp1.push_back(e); else exp0.push_back(e);
    end
  endfunction

  task automatic pulse_start(input int which);
    @(negedge clk);
    if (which == 1) bus1.start = 1'b1; else bus0.start = 1'b1;
    @(negedge clk);
    bus0.start = 1'b0;
    bus1.start = 1'b0;
  endtask

  task automatic wait_idle(input int which, input int budget, input string name);
    int n = 0;
    while (((which == 1) ? bus1.hold : bus0.hold) !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= budget) begin
      failures++;
      $display("FAIL %s_timeout: hold still high after %0d cycles", name, n);
    end
  endtask

  task automatic check_dump0(input int tx_b, input int d_b, input logic err_exp, input string name);
    checks++;
    if (tx0 - tx_b !== NTX) begin
      failures++;
      $display("FAIL %s_tx_count: got %0d required %0d", name, tx0 - tx_b, NTX);
    end
    checks++;
    if (done0 - d_b !== 1) begin
      failures++;
      $display("FAIL %s_done_count: got %0d required 1", name, done0 - d_b);
    end
    checks++;
    if (bus0.err !== err_exp) begin
      failures++;
      $display("FAIL %s_err: got %b required %b", name, bus0.err, err_exp);
    end
    checks++;
    if (exp0.size() !== 0) begin
      failures++;
      $display("FAIL %s_missing: %0d expected bytes never sent, required 0", name, exp0.size());
    end
  endtask

  task automatic test_reset;
    acc0 = SPEC_ACC;
    acc1 = SPEC_ACC;
    bus0.start = 1'b0;
    bus1.start = 1'b0;
    nRst = 1'b0;
    #12;
    checks++;
    if ({bus0.sel, bus0.data_tx, bus0.transmit, bus0.hold, bus0.done, bus0.err} !== 16'h0) begin
      failures++;
      $display("FAIL reset_lsb: got %04h required 0000",
               {bus0.sel, bus0.data_tx, bus0.transmit, bus0.hold, bus0.done, bus0.err});
    end
    checks++;
    if ({bus1.sel, bus1.data_tx, bus1.transmit, bus1.hold, bus1.done, bus1.err} !== 16'h0) begin
      failures++;
      $display("FAIL reset_msb: got %04h required 0000",
               {bus1.sel, bus1.data_tx, bus1.transmit, bus1.hold, bus1.done, bus1.err});
    end
    @(negedge clk);
    nRst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_lsb_dump;
    int tx_b = tx0;
    int d_b  = done0;
    acc0 = SPEC_ACC;
    push_dump(0, acc0);
    @(negedge clk);
    bus0.start = 1'b1;
    checks++;
    if (bus0.hold !== 1'b0) begin
      failures++;
      $display("FAIL hold_before_accept: got %b required 0", bus0.hold);
    end
    @(negedge clk);
    bus0.start = 1'b0;
    checks++;
    if ({bus0.hold, bus0.transmit} !== 2'b10) begin
      failures++;
      $display("FAIL latency_setup: hold,transmit got %b required 10", {bus0.hold, bus0.transmit});
    end
    @(negedge clk);
    checks++;
    if (bus0.transmit !== 1'b1) begin
      failures++;
      $display("FAIL latency_send: transmit got %b required 1", bus0.transmit);
    end
    wait_idle(0, 1000, "lsb_dump");
    repeat (3) @(negedge clk);
    check_dump0(tx_b, d_b, 1'b0, "lsb_dump");
  endtask

  task automatic test_msb_dump;
    int tx_b = tx1;
    int d_b  = done1;
    acc1 = SPEC_ACC;
    push_dump(1, acc1);
    pulse_start(1);
    wait_idle(1, 1000, "msb_dump");
    repeat (3) @(negedge clk);
    checks++;
    if (tx1 - tx_b !== NTX || done1 - d_b !== 1 || exp1.size() !== 0) begin
      failures++;
      $display("FAIL msb_dump_counts: tx=%0d done=%0d left=%0d required tx=%0d done=1 left=0",
               tx1 - tx_b, done1 - d_b, exp1.size(), NTX);
    end
    checks++;
    if (bus1.err !== 1'b0) begin
      failures++;
      $display("FAIL msb_dump_err: got %b required 0", bus1.err);
    end
  endtask

  task automatic test_timeout;
    int tx_b = tx0;
    int d_b  = done0;
    stuck = 1'b1;
    push_dump(0, acc0);
    pulse_start(0);
    wait_idle(0, 2000, "timeout");
    repeat (3) @(negedge clk);
    stuck = 1'b0;
    check_dump0(tx_b, d_b, 1'b1, "timeout");
    checks++;
    if (gap0 !== BUSY_TO_DEF + 2) begin
      failures++;
      $display("FAIL timeout_gap: transmit spacing got %0d required %0d", gap0, BUSY_TO_DEF + 2);
    end
  endtask

  task automatic test_ignore_start;
    int tx_b = tx0;
    int d_b  = done0;
    force_busy = 1'b1;
    pulse_start(0);
    repeat (4) @(negedge clk);
    checks++;
    if (bus0.hold !== 1'b0 || tx0 !== tx_b || bus0.err !== 1'b1) begin
      failures++;
      $display("FAIL start_while_busy: hold=%b tx=%0d err=%b required hold=0 tx=0 err=1",
               bus0.hold, tx0 - tx_b, bus0.err);
    end
    force_busy = 1'b0;
    @(negedge clk);
    push_dump(0, acc0);
    pulse_start(0);
    checks++;
    if (bus0.err !== 1'b0) begin
      failures++;
      $display("FAIL err_clear_on_start: got %b required 0", bus0.err);
    end
    for (int k = 0; k < 5; k++) begin
      repeat (20) @(negedge clk);
      bus0.start = 1'b1;
      @(negedge clk);
      bus0.start = 1'b0;
    end
    wait_idle(0, 1000, "back_to_back");
    repeat (30) @(negedge clk);
    check_dump0(tx_b, d_b, 1'b0, "back_to_back");
  endtask

  task automatic test_reset_mid_dump;
    int tx_b = tx0;
    int d_b;
    int n = 0;
    acc0 = {$urandom, $urandom, $urandom, $urandom};
    push_dump(0, acc0);
    pulse_start(0);
    while (tx0 - tx_b < 5 && n < 500) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 500) begin
      failures++;
      $display("FAIL reset_mid_wait: got %0d transmits required 5", tx0 - tx_b);
    end
    repeat (3) @(negedge clk);
    #2;
    nRst = 1'b0;
    #1;
    checks++;
    if ({bus0.sel, bus0.data_tx, bus0.transmit, bus0.hold, bus0.done, bus0.err} !== 16'h0) begin
      failures++;
      $display("FAIL reset_mid_outs: got %04h required 0000",
               {bus0.sel, bus0.data_tx, bus0.transmit, bus0.hold, bus0.done, bus0.err});
    end
    exp0.delete();
    @(negedge clk);
    nRst = 1'b1;
    repeat (2) @(negedge clk);
    tx_b = tx0;
    d_b  = done0;
    push_dump(0, acc0);
    pulse_start(0);
    wait_idle(0, 1000, "restart");
    repeat (3) @(negedge clk);
    check_dump0(tx_b, d_b, 1'b0, "restart");
  endtask

  initial begin
    test_reset();
    test_lsb_dump();
    test_msb_dump();
    test_timeout();
    test_ignore_start();
    test_reset_mid_dump();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/acc_dump_seq.md
ACC_DUMP_SEQ -- requirements
Module: acc_dump_seq

Interface
REQ-001 Parameter NBYTES, default 16, number of accumulator bytes streamed per dump (2..16).
REQ-002 Parameter MSB_FIRST, default 0, byte order: 0 streams sel 0 up to NBYTES-1; 1 streams NBYTES-1 down to 0.
REQ-003 Parameter BUSY_TO, default 15, max cycles to wait for busy_tx to rise after a transmit pulse.
REQ-004 Port clk  input  1  single clock, rising edge.
REQ-005 Port nRst  input  1  asynchronous active-low reset.
REQ-006 Port start  input  1  dump request pulse from ctrl.
REQ-007 Port busy_tx  input  1  uart transmitter busy.
REQ-008 Port mux_data  input  8  byte from the accumulator mux (combinational on sel).
REQ-009 Port sel  output  4  byte select to the accumulator mux.
REQ-010 Port data_tx  output  8  byte presented to uart data_tx.
REQ-011 Port transmit  output  1  one-cycle send strobe to uart.
REQ-012 Port hold  output  1  high while dumping; ctrl gates acc add/clear with it.
REQ-013 Port done  output  1  one-cycle pulse after the last byte completes.
REQ-014 Port err  output  1  sticky flag: a busy_tx timeout occurred; cleared by next accepted start.

Function
REQ-015 States: IDLE, SETUP, SEND, WAIT_HI, WAIT_LO, DONE.
REQ-016 IDLE: start=1 and busy_tx=0 -> SETUP, sel loaded with first index (0, or NBYTES-1 if MSB_FIRST), err cleared; start with busy_tx=1 is ignored (dropped, not queued).
REQ-017 SETUP: one settle cycle for the mux -> SEND.
REQ-018 SEND: transmit=1 for exactly one cycle, data_tx registered from mux_data in that cycle -> WAIT_HI.
REQ-019 WAIT_HI: busy_tx=1 -> WAIT_LO; cycle counter reaching BUSY_TO with busy_tx=0 -> set err, treat byte as sent, go to advance step.
REQ-020 WAIT_LO: busy_tx=0 -> advance: last index -> DONE, else step sel by +1 (or -1 if MSB_FIRST) -> SETUP.
REQ-021 DONE: done=1 one cycle -> IDLE.
REQ-022 transmit never asserts while busy_tx=1 or outside SEND.
REQ-023 hold=1 in every state except IDLE; it rises the cycle after start is accepted.
REQ-024 start while not IDLE is ignored.
REQ-025 Latency: start accepted at edge n -> transmit high in cycle n+2; per byte minimum 4 cycles plus uart busy time.
REQ-026 sel never leaves 0..NBYTES-1; no wrap past last index.
REQ-027 data_tx holds its value from SEND until the next SEND.

Reset
REQ-028 nRst low: state IDLE, sel=0, data_tx=0, transmit=0, hold=0, done=0, err=0, timeout counter 0, immediately and asynchronously, including mid-dump; no partial byte resumes after reset.

Configuration
REQ-029 Macro DUMP_HEADER_EN defined: each dump first sends header byte 8'hA5 through the same SEND/WAIT_HI/WAIT_LO handshake (data_tx from constant, sel at first index), then NBYTES accumulator bytes; total NBYTES+1 transmits.
REQ-030 Macro undefined: no header state or logic; exactly NBYTES transmits per dump.

Structure
REQ-031 Shared package perceptron_pkg holds the state enum, the header constant 8'hA5, and the default NBYTES/BUSY_TO constants.
REQ-032 One sub-module, dump_timer: BUSY_TO down-counter with load and expire outputs; everything else flat.

Verification
REQ-033 Uart model with busy 10 cycles after transmit; start pulse, acc=128'h0F0E..0100 -> 16 transmits carrying 8'h00..8'h0F, done once, err=0.
REQ-034 MSB_FIRST=1, same acc -> bytes 8'h0F down to 8'h00, sel sequence 15..0.
REQ-035 busy_tx stuck 0 -> each byte times out after BUSY_TO cycles, err=1, dump still completes with 16 transmits and done.
REQ-036 start pulses during dump and start while busy_tx=1 in IDLE -> no extra transmits, no second done.
REQ-037 nRst low after 5th byte -> all outputs zero at once; new start restarts from sel 0.
REQ-038 DUMP_HEADER_EN defined -> first transmit carries 8'hA5, then 16 data bytes, 17 transmits total.
